vproc_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream memory-mapped target between `NUM_MASTERS` VProc bus masters. Each master port carries the VProc bus signals:

- Requests: Addr, WE, RD, DataOut, Burst, BurstFirst, BurstLast.
- Responses: DataIn, WRAck, RDAck.

The block sits between the VProc instances and a single slave model. It locks the grant for a whole transfer or burst and times out stalled accesses so no VProc node hangs.

---
 rtl/vproc_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_vproc_bus_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_bus_arbiter.sv
// Round-robin arbiter sharing one memory-mapped target among NUM_MASTERS VProc masters; grant locked per transfer/burst.
// Grant registered on the request edge, S-side mux and acks combinational; stalled accesses get a forced error ack after TIMEOUT cycles.
module vproc_bus_arbiter #(
    parameter int          NUM_MASTERS = 2,
    parameter int          TIMEOUT     = 1024,
    parameter logic [31:0] ERR_DATA    = 32'hDEADDEAD
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [32*NUM_MASTERS-1:0] MAddr,
    input  logic [NUM_MASTERS-1:0]    MWE,
    input  logic [NUM_MASTERS-1:0]    MRD,
    input  logic [32*NUM_MASTERS-1:0] MDataOut,
    input  logic [12*NUM_MASTERS-1:0] MBurst,
    input  logic [NUM_MASTERS-1:0]    MBurstFirst,
    input  logic [NUM_MASTERS-1:0]    MBurstLast,
    output logic [31:0]               MDataIn,
    output logic [NUM_MASTERS-1:0]    MWRAck,
    output logic [NUM_MASTERS-1:0]    MRDAck,
    output logic [31:0]               SAddr,
    output logic [31:0]               SDataOut,
    output logic                      SWE,
    output logic                      SRD,
    output logic                      SBurstFirst,
    output logic                      SBurstLast,
    output logic [11:0]               SBurst,
    input  logic [31:0]               SDataIn,
    input  logic                      SWRAck,
    input  logic                      SRDAck,
    output logic [NUM_MASTERS-1:0]    Grant,
    output logic                      Busy,
    output logic                      TimeoutErr
);
    localparam int IW     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] CNT_LIM = CW'(TLIM_I);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       last, last_nxt;   // doubles as the granted index while BUSY
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [NUM_MASTERS-1:0] req;
    logic                found;
    logic [IW-1:0]       win;
    logic                g_we, g_rd, g_blast, g_bfirst;
    logic [31:0]         g_addr, g_data;
    logic [11:0]         g_burst;
    logic                s_we_raw, s_rd_raw, real_ack, expire;

    assign req  = MWE | MRD;
    assign Busy = (state == BUSY);

    always_comb begin
        found = 1'b0;
        win   = last;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            if (!found && req[(int'(last) + off) % NUM_MASTERS]) begin
                found = 1'b1;
                win   = IW'((int'(last) + off) % NUM_MASTERS);
            end
        end
    end

    assign g_we     = MWE[last];
    assign g_rd     = MRD[last];
    assign g_blast  = MBurstLast[last];
    assign g_bfirst = MBurstFirst[last];
    assign g_addr   = MAddr[32*last +: 32];
    assign g_data   = MDataOut[32*last +: 32];
    assign g_burst  = MBurst[12*last +: 12];

    assign s_we_raw = Busy & g_we;
    assign s_rd_raw = Busy & g_rd;
    assign real_ack = (SWRAck & s_we_raw) | (SRDAck & s_rd_raw);
    // A real downstream ack in the expiry cycle takes precedence over the forced one.
    assign expire   = (TIMEOUT != 0) && Busy && !real_ack && (g_we || g_rd) && (cnt == CNT_LIM);

    assign SWE         = s_we_raw & ~expire;
    assign SRD         = s_rd_raw & ~expire;
    assign SAddr       = Busy ? g_addr : 32'd0;
    assign SDataOut    = Busy ? g_data : 32'd0;
    assign SBurst      = Busy ? g_burst : 12'd0;
    assign SBurstFirst = Busy & g_bfirst;
    assign SBurstLast  = Busy & g_blast;
    assign TimeoutErr  = expire;
    assign MDataIn     = !Busy ? 32'd0 : (expire ? ERR_DATA : SDataIn);

    always_comb begin
        Grant  = '0;
        MWRAck = '0;
        MRDAck = '0;
        if (Busy) begin
            Grant[last]  = 1'b1;
            MWRAck[last] = (SWRAck & SWE) | (expire & g_we);
            MRDAck[last] = (SRDAck & SRD) | (expire & g_rd);
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BUSY;
                    last_nxt  = win;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (real_ack) begin
                    cnt_nxt = '0;
                    if ((g_burst == 12'd0) || g_blast)
                        state_nxt = IDLE;
                end else if (expire || !(g_we || g_rd)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            last  <= IW'(NUM_MASTERS - 1);
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_vproc_bus_arbiter.sv
// Directed checks for vproc_bus_arbiter: table of single-cycle vectors plus burst, timeout and reset sequences.
module tb_vproc_bus_arbiter;
    localparam int N = 2;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [63:0]   MAddr;
    logic [1:0]    MWE, MRD;
    logic [63:0]   MDataOut;
    logic [23:0]   MBurst;
    logic [1:0]    MBurstFirst, MBurstLast;
    logic [31:0]   MDataIn;
    logic [1:0]    MWRAck, MRDAck;
    logic [31:0]   SAddr, SDataOut;
    logic          SWE, SRD, SBurstFirst, SBurstLast;
    logic [11:0]   SBurst;
    logic [31:0]   SDataIn;
    logic          SWRAck, SRDAck;
    logic [1:0]    Grant;
    logic          Busy, TimeoutErr;

    int total = 0;
    int bad   = 0;

    vproc_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT(16), .ERR_DATA(32'hDEADDEAD)) dut (
        .Clk(Clk), .Reset(Reset), .MAddr(MAddr), .MWE(MWE), .MRD(MRD),
        .MDataOut(MDataOut), .MBurst(MBurst), .MBurstFirst(MBurstFirst),
        .MBurstLast(MBurstLast), .MDataIn(MDataIn), .MWRAck(MWRAck), .MRDAck(MRDAck),
        .SAddr(SAddr), .SDataOut(SDataOut), .SWE(SWE), .SRD(SRD),
        .SBurstFirst(SBurstFirst), .SBurstLast(SBurstLast), .SBurst(SBurst),
        .SDataIn(SDataIn), .SWRAck(SWRAck), .SRDAck(SRDAck),
        .Grant(Grant), .Busy(Busy), .TimeoutErr(TimeoutErr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  mwe, mrd;
        logic        swrack, srdack;
        logic [31:0] sdin;
        logic [1:0]  e_grant;
        logic        e_swe, e_srd;
        logic [31:0] e_saddr;
        logic [1:0]  e_wrack, e_rdack;
        logic [31:0] e_mdin;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        MWE = 2'b00; MRD = 2'b00; MBurst = '0; MBurstFirst = 2'b00; MBurstLast = 2'b00;
        SWRAck = 1'b0; SRDAck = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(Grant), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_strobes"}, {28'd0, SWE, SRD, SBurstFirst, SBurstLast}, 32'd0);
        chk({tag, "_saddr"}, SAddr, 32'd0);
        chk({tag, "_sdout"}, SDataOut, 32'd0);
        chk({tag, "_sburst"}, 32'(SBurst), 32'd0);
        chk({tag, "_acks"}, {28'd0, MWRAck, MRDAck}, 32'd0);
        chk({tag, "_mdin"}, MDataIn, 32'd0);
        chk({tag, "_terr"}, 32'(TimeoutErr), 32'd0);
    endtask

    // Stalled read from master 0; optionally the slave acks exactly in the expiry cycle.
    task automatic run_timeout(input bit ack_at_end);
        MRD = 2'b01; SDataIn = 32'h0000_0055; SRDAck = 1'b0;
        #1 chk("to_idle_grant", 32'(Grant), 32'd0);
        step();
        for (int c = 1; c <= 16; c++) begin
            SRDAck = ack_at_end && (c == 16);
            #1;
            if (c < 16) begin
                chk("to_wait_srd", 32'(SRD), 32'd1);
                chk("to_wait_ack", 32'(MRDAck), 32'd0);
                chk("to_wait_terr", 32'(TimeoutErr), 32'd0);
            end else if (!ack_at_end) begin
                chk("to_exp_ack", 32'(MRDAck), 32'b01);
                chk("to_exp_mdin", MDataIn, 32'hDEADDEAD);
                chk("to_exp_terr", 32'(TimeoutErr), 32'd1);
                chk("to_exp_srd", 32'(SRD), 32'd0);
            end else begin
                chk("to_race_ack", 32'(MRDAck), 32'b01);
                chk("to_race_mdin", MDataIn, 32'h0000_0055);
                chk("to_race_terr", 32'(TimeoutErr), 32'd0);
                chk("to_race_srd", 32'(SRD), 32'd1);
            end
            step();
        end
        SRDAck = 1'b0;
        #1 chk("to_after_grant", 32'(Grant), 32'd0);
        chk("to_after_terr", 32'(TimeoutErr), 32'd0);
        step();
        SRDAck = 1'b1; SDataIn = 32'h0000_0077;
        #1 chk("to_next_grant", 32'(Grant), 32'b01);
        chk("to_next_ack", 32'(MRDAck), 32'b01);
        chk("to_next_mdin", MDataIn, 32'h0000_0077);
        step();
        MRD = 2'b00; SRDAck = 1'b0;
        step();
    endtask

    initial begin
        MAddr    = {32'h0000_0200, 32'h0000_0100};
        MDataOut = {32'hCAFE_F00D, 32'h1234_5678};
        SDataIn  = 32'h5A5A_5A5A;
        idle_inputs();
        Reset = 1'b1;

        //        mwe    mrd    wak   rak   sdin          grant  swe   srd   saddr         wrack  rdack  mdin
        vecs[0]  = '{2'b01, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 32'h0};
        vecs[1]  = '{2'b01, 2'b00, 1'b0, 1'b0, 32'h0,        2'b01, 1'b1, 1'b0, 32'h100,      2'b00, 2'b00, 32'h0};
        vecs[2]  = '{2'b01, 2'b00, 1'b0, 1'b0, 32'h0,        2'b01, 1'b1, 1'b0, 32'h100,      2'b00, 2'b00, 32'h0};
        vecs[3]  = '{2'b01, 2'b00, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 1'b0, 32'h100,      2'b01, 2'b00, 32'h0};
        vecs[4]  = '{2'b00, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 32'h0};
        vecs[5]  = '{2'b00, 2'b11, 1'b0, 1'b0, 32'hA1,       2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 32'h0};
        vecs[6]  = '{2'b00, 2'b11, 1'b1, 1'b1, 32'h11111111, 2'b10, 1'b0, 1'b1, 32'h200,      2'b00, 2'b10, 32'h11111111};
        vecs[7]  = '{2'b00, 2'b11, 1'b0, 1'b1, 32'h0,        2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 32'h0};
        vecs[8]  = '{2'b00, 2'b11, 1'b0, 1'b1, 32'h22222222, 2'b01, 1'b0, 1'b1, 32'h100,      2'b00, 2'b01, 32'h22222222};
        vecs[9]  = '{2'b00, 2'b11, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 32'h0};
        vecs[10] = '{2'b00, 2'b11, 1'b0, 1'b1, 32'h33333333, 2'b10, 1'b0, 1'b1, 32'h200,      2'b00, 2'b10, 32'h33333333};
        vecs[11] = '{2'b00, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 32'h0};

        repeat (2) @(negedge Clk);
        chk_reset_outputs("rst");
        Reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            MWE = vecs[i].mwe; MRD = vecs[i].mrd;
            SWRAck = vecs[i].swrack; SRDAck = vecs[i].srdack; SDataIn = vecs[i].sdin;
            #1;
            chk($sformatf("v%0d_grant", i), 32'(Grant), 32'(vecs[i].e_grant));
            chk($sformatf("v%0d_swe", i), 32'(SWE), 32'(vecs[i].e_swe));
            chk($sformatf("v%0d_srd", i), 32'(SRD), 32'(vecs[i].e_srd));
            chk($sformatf("v%0d_saddr", i), SAddr, vecs[i].e_saddr);
            chk($sformatf("v%0d_wrack", i), 32'(MWRAck), 32'(vecs[i].e_wrack));
            chk($sformatf("v%0d_rdack", i), 32'(MRDAck), 32'(vecs[i].e_rdack));
            chk($sformatf("v%0d_mdin", i), MDataIn, vecs[i].e_mdin);
            if (vecs[i].e_swe)
                chk($sformatf("v%0d_sdout", i), SDataOut, 32'h1234_5678);
            step();
        end

        // Master 1 write burst of 4, master 0 joins once master 1 holds the grant.
        idle_inputs();
        MWE = 2'b10; MBurst = {12'd4, 12'd0}; MBurstFirst = 2'b10;
        #1 chk("bu_idle_grant", 32'(Grant), 32'd0);
        step();
        MRD = 2'b01; SWRAck = 1'b1;
        #1 chk("bu_w1_grant", 32'(Grant), 32'b10);
        chk("bu_w1_swe", 32'(SWE), 32'd1);
        chk("bu_w1_sdout", SDataOut, 32'hCAFE_F00D);
        chk("bu_w1_sburst", 32'(SBurst), 32'd4);
        chk("bu_w1_first", 32'(SBurstFirst), 32'd1);
        chk("bu_w1_wrack", 32'(MWRAck), 32'b10);
        step();
        MBurstFirst = 2'b00;
        #1 chk("bu_w2_grant", 32'(Grant), 32'b10);
        chk("bu_w2_wrack", 32'(MWRAck), 32'b10);
        step();
        SWRAck = 1'b0;
        #1 chk("bu_stall_grant", 32'(Grant), 32'b10);
        chk("bu_stall_acks", {28'd0, MWRAck, MRDAck}, 32'd0);
        step();
        SWRAck = 1'b1;
        #1 chk("bu_w3_grant", 32'(Grant), 32'b10);
        step();
        MBurstLast = 2'b10;
        #1 chk("bu_w4_grant", 32'(Grant), 32'b10);
        chk("bu_w4_last", 32'(SBurstLast), 32'd1);
        chk("bu_w4_wrack", 32'(MWRAck), 32'b10);
        step();
        MWE = 2'b00; MBurstLast = 2'b00; MBurst = '0; SWRAck = 1'b0;
        #1 chk("bu_rel_grant", 32'(Grant), 32'd0);
        chk("bu_rel_busy", 32'(Busy), 32'd0);
        step();
        SRDAck = 1'b1; SDataIn = 32'h0000_0A0A;
        #1 chk("bu_m0_grant", 32'(Grant), 32'b01);
        chk("bu_m0_rdack", 32'(MRDAck), 32'b01);
        chk("bu_m0_mdin", MDataIn, 32'h0000_0A0A);
        step();
        idle_inputs();
        #1 chk("bu_end_grant", 32'(Grant), 32'd0);
        step();

        run_timeout(1'b0);
        run_timeout(1'b1);

        // Reset asserted during word 2 of a master 1 burst.
        idle_inputs();
        MWE = 2'b10; MBurst = {12'd4, 12'd0}; MBurstFirst = 2'b10;
        step();
        SWRAck = 1'b1;
        #1 chk("rb_w1_grant", 32'(Grant), 32'b10);
        step();
        MBurstFirst = 2'b00; SDataIn = 32'h0000_0099;
        #1 chk("rb_w2_grant", 32'(Grant), 32'b10);
        #1 Reset = 1'b1;
        #1 chk_reset_outputs("rb_async");
        @(posedge Clk);
        #1 chk_reset_outputs("rb_hold");
        @(negedge Clk);
        Reset = 1'b0;
        idle_inputs();
        MRD = 2'b11;
        #1 chk("rb_rel_grant", 32'(Grant), 32'd0);
        step();
        #1 chk("rb_first_grant", 32'(Grant), 32'b01);
        step();
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
